// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer and its next-PC selector.
package pc_seq_pkg;

  // Fetch controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_e;

  // Every instruction is one 32-bit word
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Default program counter after reset and default misaligned-redirect vector
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selector: sequential PC+4 or redirect target, with misaligned-target handling.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a misaligned redirect
// target loads TRAP_VECTOR and raises trap; otherwise the target is force-aligned.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_next_o,
  output logic        trap_o
);

`ifndef MISALIGN_TRAP_EN
  // The trap vector and low target bits have no role when targets are force-aligned
  logic unused_bits;
  assign unused_bits = ^{TRAP_VECTOR, redirect_pc_i[1:0]};
`endif

  // Pick the PC for the next fetch; the sequential add wraps modulo 2^32
  always_comb begin
    pc_next_o = pc_i + INSTR_BYTES;
    trap_o    = 1'b0;
    if (redirect_i) begin
`ifdef MISALIGN_TRAP_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        pc_next_o = TRAP_VECTOR;
        trap_o    = 1'b1;
      end else begin
        pc_next_o = redirect_pc_i;
      end
`else
      pc_next_o = {redirect_pc_i[31:2], 2'b00};
`endif
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch controller owning the PC: request, wait for data, hold for
// the core, then advance sequentially or to a redirect target.
// Optional feature macro: MISALIGN_TRAP_EN (handled inside pc_next_sel).
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        core_done,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        trap,
  output logic [31:0] pc,
  output logic [31:0] retire_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        trap_d;
  logic        trap_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] retire_q;

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_sel (
    .pc_i          (pc_q),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_next_o     (pc_d),
    .trap_o        (trap_d)
  );

  // Fetch FSM with registered request/valid/trap outputs, PC register and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      trap_q     <= 1'b0;
      retire_q   <= 32'h0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (core_done) begin
            pc_q     <= pc_d;
            trap_q   <= trap_d;
            retire_q <= retire_q + 32'd1;
            valid_q  <= 1'b0;
            if (halt) begin
              state_q <= HALTED;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        HALTED: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign trap        = trap_q;
  assign pc          = pc_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer; expectations follow
// MISALIGN_TRAP_EN when it is defined for the build.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        core_done;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        trap;
  logic [31:0] pc;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .core_done   (core_done),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .trap        (trap),
    .pc          (pc),
    .retire_cnt  (retire_cnt)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold one set of input values for a single cycle, then return them to idle
  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic d, input logic r, input logic [31:0] rp,
                               input logic h);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    core_done = d; redirect = r; redirect_pc = rp; halt = h;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    core_done = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    core_done = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc); end
    checks++; if ({instr_valid, trap} !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid_trap: got %b expected 00", {instr_valid, trap}); end
    checks++; if ({instr, instr_pc, retire_cnt} !== 96'h0) begin errors++; $display("[TB] FAIL reset_regs: got %h %h %h expected zeros", instr, instr_pc, retire_cnt); end
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] addr;
      logic [31:0] data;
      addr = 32'(i * 4);
      data = 32'h1000_0013 + 32'(i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== addr) begin errors++; $display("[TB] FAIL seq_req[%0d]: got %b/%h expected 1/%h", i, imem_req, imem_addr, addr); end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait[%0d]: got req %b valid %b expected 0 0", i, imem_req, instr_valid); end
      applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (instr_valid !== 1'b1 || instr !== data || instr_pc !== addr) begin errors++; $display("[TB] FAIL seq_exec[%0d]: got %b %h %h expected 1 %h %h", i, instr_valid, instr, instr_pc, data, addr); end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (retire_cnt !== 32'(i + 1) || pc !== addr + 32'd4) begin errors++; $display("[TB] FAIL seq_done[%0d]: got cnt %0d pc %h expected %0d %h", i, retire_cnt, pc, i + 1, addr + 32'd4); end
    end
  endtask

  task automatic test_stalls;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL gnt_stall[%0d]: got %b/%h expected 1/0000000c", i, imem_req, imem_addr); end
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL gnt_to_wait: got req %b valid %b expected 0 0", imem_req, instr_valid); end
    tick(); tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rvalid_stall: got req %b valid %b expected 0 0", imem_req, instr_valid); end
    applyStimulus(1'b0, 1'b1, 32'h0000_00AA, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hAA || instr_pc !== 32'hC) begin errors++; $display("[TB] FAIL done_stall: got %b %h %h expected 1 000000aa 0000000c", instr_valid, instr, instr_pc); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (pc !== 32'h10 || retire_cnt !== 32'd4) begin errors++; $display("[TB] FAIL stall_done: got pc %h cnt %0d expected 00000010 4", pc, retire_cnt); end
  endtask

  task automatic test_redirect;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc !== 32'h40) begin errors++; $display("[TB] FAIL redirect_addr: got %b %h %h expected 1 00000040 00000040", imem_req, imem_addr, pc); end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("[TB] FAIL redirect_instr_pc: got %h expected 00000040", instr_pc); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (pc !== 32'h44 || retire_cnt !== 32'd6) begin errors++; $display("[TB] FAIL redirect_after: got pc %h cnt %0d expected 00000044 6", pc, retire_cnt); end
  endtask

  task automatic test_misalign;
    logic [31:0] expPc;
    logic        expTrap;
`ifdef MISALIGN_TRAP_EN
    expPc = 32'h100; expTrap = 1'b1;
`else
    expPc = 32'h40;  expTrap = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (trap !== 1'b0) begin errors++; $display("[TB] FAIL trap_before: got %b expected 0", trap); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0042, 1'b0);
    checks++; if (pc !== expPc || trap !== expTrap) begin errors++; $display("[TB] FAIL misalign: got pc %h trap %b expected %h %b", pc, trap, expPc, expTrap); end
    tick();
    checks++; if (trap !== 1'b0 || retire_cnt !== 32'd7) begin errors++; $display("[TB] FAIL trap_pulse: got trap %b cnt %0d expected 0 7", trap, retire_cnt); end
  endtask

  task automatic test_wrap;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_setup: got %h expected fffffffc", pc); end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_instr_pc: got %h expected fffffffc", instr_pc); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (pc !== 32'h0 || imem_addr !== 32'h0 || retire_cnt !== 32'd9) begin errors++; $display("[TB] FAIL wrap: got pc %h addr %h cnt %0d expected 0 0 9", pc, imem_addr, retire_cnt); end
  endtask

  task automatic test_reset_midflight;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    checks++; if (instr_valid !== 1'b0 || retire_cnt !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midflight_reset: got valid %b cnt %0d pc %h req %b expected 0 0 0 0", instr_valid, retire_cnt, pc, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_idle: got req %b addr %h valid %b expected 1 0 0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("[TB] FAIL stale_req: got req %b valid %b instr %h expected 1 0 0", imem_req, instr_valid, instr); end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (instr !== 32'h55 || instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL restart_fetch: got %h %h expected 00000055 0", instr, instr_pc); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (retire_cnt !== 32'd1 || pc !== 32'h4) begin errors++; $display("[TB] FAIL restart_done: got cnt %0d pc %h expected 1 4", retire_cnt, pc); end
  endtask

  task automatic test_halt;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
    checks++; if (pc !== 32'h80 || imem_req !== 1'b0 || instr_valid !== 1'b0 || retire_cnt !== 32'd2) begin errors++; $display("[TB] FAIL halt_enter: got pc %h req %b valid %b cnt %0d expected 80 0 0 2", pc, imem_req, instr_valid, retire_cnt); end
    for (int i = 0; i < 12; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1; core_done = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h80 || retire_cnt !== 32'd2) begin errors++; $display("[TB] FAIL halted[%0d]: got req %b valid %b pc %h cnt %0d expected 0 0 80 2", i, imem_req, instr_valid, pc, retire_cnt); end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; core_done = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_sequential();
    test_stalls();
    test_redirect();
    test_misalign();
    test_wrap();
    test_reset_midflight();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
